pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage pipeline.
- Drives en/flush for the fetch, decode, execute and memory latches, plus PC enable.
- Resolves, in fixed priority: data-memory wait, control redirect, load-use hazard and instruction-memory wait.
- Owns the halt drain sequence and the sticky halt output.

Parameters:
- STALL_CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  in  1  system clock
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN  in  1  memory-stage load pending
- mem_dWEN  in  1  memory-stage store pending
- mem_redirect  in  1  memory stage resolves a taken branch or jump (Branch&zero | bne&!zero | Jump | JAL | jr)
- mem_halt  in  1  halt instruction in memory stage
- ex_dREN  in  1  execute-stage instruction is a load
- ex_wsel  in  regbits_t  execute-stage destination register
- id_rs, id_rt  in  regbits_t  decode-stage source registers
- pc_en  out  1  PC register update enable
- fl_en, fl_flush  out  1 each  fetch latch controls
- dl_en, dl_flush  out  1 each  decode latch controls
- el_en, el_flush  out  1 each  execute latch controls
- ml_en, ml_flush  out  1 each  memory latch controls
- halt  out  1  sticky CPU halted
- stall_cnt, flush_cnt  out  STALL_CNT_W each  performance counters

Behaviour:
- Clock CLK, reset nRST: one clock; reset is asynchronous and active-low.
- FSM states (pipe_state_t): RUN, DRAIN, HALTED. Reset state: RUN. Reset value of halt: 0.
- All latch controls are combinational from state and inputs. With nRST low they evaluate as RUN.
- Precedence in RUN, highest first:
  1. DWAIT, when (mem_dREN | mem_dWEN) & !dhit: all en=0, all flush=0, pc_en=0. The whole pipe freezes.
  2. REDIRECT, when mem_redirect: pc_en=1; fl_flush=dl_flush=el_flush=1; ml_en=1.
  3. LOADUSE, when ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt): pc_en=0, fl_en=0; dl_flush=1 (bubble into execute); el_en=ml_en=1.
  4. IWAIT, when !ihit: pc_en=0; fl_flush=1 (bubble into decode); dl_en=el_en=ml_en=1.
  5. Otherwise: every en=1, every flush=0, pc_en=1.
- Flush takes priority over en inside a latch. Controller asserts both only where listed.
- mem_halt in RUN with no DWAIT:
  - Next state DRAIN.
  - This cycle: pc_en=0, fl/dl/el_flush=1, ml_en=1. The halt instruction moves to writeback.
  - mem_halt outranks REDIRECT and LOADUSE.
- DRAIN (exactly one cycle): pc_en=0, all en=0, ml_flush=1. Next state HALTED, halt<=1.
- HALTED: pc_en=0, all en=0, all flush=0, halt=1 until nRST. All inputs are ignored.
- mem_halt during DWAIT: stay in RUN until dhit, then take the halt transition.
- Reset asserted mid-drain: state returns to RUN and halt clears immediately (async).
- Latency: every control decision takes effect on the same CLK edge. No registered delay except the FSM state.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments on every RUN cycle in DWAIT, LOADUSE or IWAIT.
  - flush_cnt increments on every REDIRECT cycle.
  - Both saturate at all-ones, reset to 0, and freeze in DRAIN/HALTED.
- Undefined: both outputs tied to 0 and no counter flops are built.

Decomposition:
- Add to cpu_types_pkg: typedef enum logic [1:0] pipe_state_t {RUN, DRAIN, HALTED}.
- regbits_t is already provided by cpu_types_pkg.
- Sub-module hazard_detect: purely combinational load-use comparator. Inputs ex_dREN, ex_wsel, id_rs, id_rt; output lu_hazard.

Test Plan:
- Reset, then ihit=1, no hazards -> pc_en=1, all en=1, all flush=0, halt=0.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 and pc_en=0 for 3 cycles; full advance on the 4th.
- ex_dREN=1, ex_wsel=5, id_rt=5 -> pc_en=0, fl_en=0, dl_flush=1. Repeat with ex_wsel=0 -> no stall.
- mem_redirect=1 together with the load-use condition -> fl/dl/el_flush=1, pc_en=1, no stall (redirect wins).
- mem_halt=1 -> DRAIN next cycle, then halt=1 held for 10 cycles. Pulse nRST low -> halt=0 asynchronously, state RUN.
- With PIPE_CTRL_PERF_EN: 2 IWAIT cycles + 1 LOADUSE + 1 REDIRECT -> stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline sequencer state.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DRAIN  = 2'b01,
      HALTED = 2'b10
   } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: execute-stage load writing a register that decode reads.
// Latency: combinational. Backpressure: none.
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     ex_dREN,
   input  regbits_t ex_wsel,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   output logic     lu_hazard
);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign lu_hazard = ex_dREN && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: latch en/flush, PC enable, halt drain; optional counters (PIPE_CTRL_PERF_EN).
// Latency: controls combinational from state+inputs; only FSM state/halt are registered.
// Backpressure: dmem wait freezes everything; imem wait bubbles decode; load-use bubbles execute.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic                   mem_dREN,
   input  logic                   mem_dWEN,
   input  logic                   mem_redirect,
   input  logic                   mem_halt,
   input  logic                   ex_dREN,
   input  regbits_t               ex_wsel,
   input  regbits_t               id_rs,
   input  regbits_t               id_rt,
   output logic                   pc_en,
   output logic                   fl_en,
   output logic                   fl_flush,
   output logic                   dl_en,
   output logic                   dl_flush,
   output logic                   el_en,
   output logic                   el_flush,
   output logic                   ml_en,
   output logic                   ml_flush,
   output logic                   halt,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic [STALL_CNT_W-1:0] flush_cnt
);

   pipe_state_t state, state_nxt;
   logic        lu_hazard;
   logic        dwait;
   logic        stall_ev;
   logic        flush_ev;

   hazard_detect u_hazard_detect (
      .ex_dREN   (ex_dREN),
      .ex_wsel   (ex_wsel),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .lu_hazard (lu_hazard)
   );

   assign dwait = (mem_dREN || mem_dWEN) && !dhit;

   always_comb begin
      pc_en     = 1'b0;
      fl_en     = 1'b0;
      fl_flush  = 1'b0;
      dl_en     = 1'b0;
      dl_flush  = 1'b0;
      el_en     = 1'b0;
      el_flush  = 1'b0;
      ml_en     = 1'b0;
      ml_flush  = 1'b0;
      stall_ev  = 1'b0;
      flush_ev  = 1'b0;
      state_nxt = state;
      case (state)
         RUN: begin
            if (dwait) begin
               stall_ev = 1'b1;
            end else if (mem_halt) begin
               // Let the halt reach writeback while squashing everything younger.
               fl_flush  = 1'b1;
               dl_flush  = 1'b1;
               el_flush  = 1'b1;
               ml_en     = 1'b1;
               state_nxt = DRAIN;
            end else if (mem_redirect) begin
               pc_en    = 1'b1;
               fl_flush = 1'b1;
               dl_flush = 1'b1;
               el_flush = 1'b1;
               ml_en    = 1'b1;
               flush_ev = 1'b1;
            end else if (lu_hazard) begin
               dl_flush = 1'b1;
               el_en    = 1'b1;
               ml_en    = 1'b1;
               stall_ev = 1'b1;
            end else if (!ihit) begin
               fl_flush = 1'b1;
               dl_en    = 1'b1;
               el_en    = 1'b1;
               ml_en    = 1'b1;
               stall_ev = 1'b1;
            end else begin
               pc_en = 1'b1;
               fl_en = 1'b1;
               dl_en = 1'b1;
               el_en = 1'b1;
               ml_en = 1'b1;
            end
         end
         DRAIN: begin
            ml_flush  = 1'b1;
            state_nxt = HALTED;
         end
         HALTED: state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
         halt  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DRAIN) halt <= 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Events only fire in RUN, so the counters freeze once the drain begins.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   logic unused_ev;
   assign unused_ev = stall_ev ^ flush_ev;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
